// File: rtl/smoosh_pkg.sv
// Shared types and constants for the per-player motion sequencer.
package smoosh_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMoveX,
        StGravity,
        StCollide,
        StAnim,
        StCommit
    } motion_state_e;

    localparam int unsigned BTN_RIGHT = 0;
    localparam int unsigned BTN_LEFT  = 1;
    localparam int unsigned BTN_JUMP  = 3;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

endpackage

// File: rtl/player_motion_ctrl_anim_sequencer.sv
// Walk-cycle cell counter; produces source-sheet row/col offsets by accumulation.
module anim_sequencer #(
    parameter int unsigned SRC_W       = 23,
    parameter int unsigned SRC_H       = 30,
    parameter int unsigned ANIM_COLS   = 3,
    parameter int unsigned ANIM_FRAMES = 6,
    parameter int unsigned ANIM_DIV    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       walking,
    output logic [9:0] row_off,
    output logic [9:0] col_off
);

    logic [3:0] div_q, div_d;
    logic [3:0] col_idx_q, col_idx_d;
    logic [3:0] cell_q, cell_d;
    logic [9:0] row_off_q, row_off_d;
    logic [9:0] col_off_q, col_off_d;

    always_comb begin
        div_d     = div_q;
        col_idx_d = col_idx_q;
        cell_d    = cell_q;
        row_off_d = row_off_q;
        col_off_d = col_off_q;
        if (enable) begin
            if (!walking) begin
                div_d     = '0;
                col_idx_d = '0;
                cell_d    = '0;
                row_off_d = '0;
                col_off_d = '0;
            end else if (div_q == 4'(ANIM_DIV - 1)) begin
                div_d = '0;
                if (cell_q == 4'(ANIM_FRAMES - 1)) begin
                    cell_d    = '0;
                    col_idx_d = '0;
                    row_off_d = '0;
                    col_off_d = '0;
                end else begin
                    cell_d = cell_q + 4'd1;
                    // Column carry steps the row offset instead of multiplying indices.
                    if (col_idx_q == 4'(ANIM_COLS - 1)) begin
                        col_idx_d = '0;
                        col_off_d = '0;
                        row_off_d = row_off_q + 10'(SRC_H);
                    end else begin
                        col_idx_d = col_idx_q + 4'd1;
                        col_off_d = col_off_q + 10'(SRC_W);
                    end
                end
            end else begin
                div_d = div_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            col_idx_q <= '0;
            cell_q    <= '0;
            row_off_q <= '0;
            col_off_q <= '0;
        end else begin
            div_q     <= div_d;
            col_idx_q <= col_idx_d;
            cell_q    <= cell_d;
            row_off_q <= row_off_d;
            col_off_q <= col_off_d;
        end
    end

    assign row_off = row_off_q;
    assign col_off = col_off_q;

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-player motion sequencer: one multi-cycle physics/animation update per video frame.
module player_motion_ctrl
    import smoosh_pkg::*;
#(
    parameter int unsigned SPR_W       = 46,
    parameter int unsigned SPR_H       = 60,
    parameter int unsigned SRC_W       = 23,
    parameter int unsigned SRC_H       = 30,
    parameter int unsigned ANIM_COLS   = 3,
    parameter int unsigned ANIM_FRAMES = 6,
    parameter int unsigned WALK_STEP   = 5,
    parameter int          JUMP_VEL    = -12,
    parameter int          MAX_FALL    = 10,
    parameter int unsigned GRAV_DIV    = 2,
    parameter int unsigned ANIM_DIV    = 4,
    parameter int unsigned X_MAX       = 610,
    parameter int unsigned SPAWN_X     = 50,
    parameter int unsigned SPAWN_Y     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [7:0] buttons,
    input  logic [9:0] plt_x,
    input  logic [9:0] plt_y,
    input  logic [9:0] plt_w,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       facing_right,
    output logic [9:0] anim_row,
    output logic [9:0] anim_col,
    output logic       on_ground,
    output logic       update_done
);

    motion_state_e state_q, state_d;
    logic              tick_q;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic signed [7:0] vy_q, vy_d, vy_c_q;
    logic              face_q, face_d, gnd_q, gnd_d, walking_q, walking_d;
    logic [3:0]        grav_cnt_q, grav_cnt_d;
    logic              commit, anim_en;
    logic [9:0]        seq_row, seq_col;

    logic btn_right, btn_left, btn_jump;
    logic unused_btn;
    assign btn_right  = ~buttons[BTN_RIGHT];
    assign btn_left   = ~buttons[BTN_LEFT];
    assign btn_jump   = ~buttons[BTN_JUMP];
    assign unused_btn = ^{buttons[7:4], buttons[2]};

    logic [10:0]        x_sum;
    logic signed [11:0] y_next, y_next_bot;
    logic [11:0]        y_bot;
    logic               land;

    always_comb begin
        x_sum      = {1'b0, x_q} + 11'(WALK_STEP);
        y_next     = $signed({2'b00, y_q}) + $signed({{4{vy_q[7]}}, vy_q});
        y_next_bot = y_next + $signed(12'(SPR_H));
        y_bot      = {2'b00, y_q} + 12'(SPR_H);
        land       = (y_bot <= {2'b00, plt_y})
                  && (y_next_bot >= $signed({2'b00, plt_y}))
                  && (({1'b0, x_q} + 11'(SPR_W)) >= {1'b0, plt_x})
                  && ({1'b0, x_q} <= ({1'b0, plt_x} + {1'b0, plt_w}));
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        vy_d       = vy_q;
        face_d     = face_q;
        gnd_d      = gnd_q;
        walking_d  = walking_q;
        grav_cnt_d = grav_cnt_q;
        commit     = 1'b0;
        anim_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_tick && !tick_q) begin
                    x_d       = pos_x;
                    y_d       = pos_y;
                    vy_d      = vy_c_q;
                    face_d    = facing_right;
                    gnd_d     = on_ground;
                    walking_d = 1'b0;
                    state_d   = StMoveX;
                end
            end
            StMoveX: begin
                walking_d = btn_right ^ btn_left;
                if (btn_right && !btn_left) begin
                    x_d    = (x_sum > 11'(X_MAX)) ? 10'(X_MAX) : x_sum[9:0];
                    face_d = 1'b1;
                end else if (btn_left && !btn_right) begin
                    x_d    = (x_q < 10'(WALK_STEP)) ? 10'd0 : x_q - 10'(WALK_STEP);
                    face_d = 1'b0;
                end
                state_d = StGravity;
            end
            StGravity: begin
                if (btn_jump && gnd_q) begin
                    vy_d = 8'(JUMP_VEL);
                end else if (!gnd_q) begin
                    if (grav_cnt_q == 4'(GRAV_DIV - 1)) begin
                        grav_cnt_d = '0;
                        if (vy_q < $signed(8'(MAX_FALL))) vy_d = vy_q + 8'sd1;
                    end else begin
                        grav_cnt_d = grav_cnt_q + 4'd1;
                    end
                end
                state_d = StCollide;
            end
            StCollide: begin
                gnd_d = 1'b0;
                if (land) begin
                    y_d   = plt_y - 10'(SPR_H);
                    vy_d  = '0;
                    gnd_d = 1'b1;
                end else if (y_next[11]) begin
                    y_d  = '0;
                    vy_d = '0;
                end else if (y_next >= $signed(12'(SCREEN_H))) begin
                    x_d  = 10'(SPAWN_X);
                    y_d  = 10'(SPAWN_Y);
                    vy_d = '0;
                end else begin
                    y_d = y_next[9:0];
                end
                state_d = StAnim;
            end
            StAnim: begin
                anim_en = 1'b1;
                state_d = StCommit;
            end
            StCommit: begin
                commit  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tick_q     <= 1'b0;
            x_q        <= 10'(SPAWN_X);
            y_q        <= 10'(SPAWN_Y);
            vy_q       <= '0;
            face_q     <= 1'b0;
            gnd_q      <= 1'b0;
            walking_q  <= 1'b0;
            grav_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tick_q     <= frame_tick;
            x_q        <= x_d;
            y_q        <= y_d;
            vy_q       <= vy_d;
            face_q     <= face_d;
            gnd_q      <= gnd_d;
            walking_q  <= walking_d;
            grav_cnt_q <= grav_cnt_d;
        end
    end

    // Visible state moves only on the commit edge, so an aborted update leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x        <= 10'(SPAWN_X);
            pos_y        <= 10'(SPAWN_Y);
            vy_c_q       <= '0;
            facing_right <= 1'b0;
            on_ground    <= 1'b0;
            anim_row     <= '0;
            anim_col     <= '0;
            update_done  <= 1'b0;
        end else begin
            update_done <= commit;
            if (commit) begin
                pos_x        <= x_q;
                pos_y        <= y_q;
                vy_c_q       <= vy_q;
                facing_right <= face_q;
                on_ground    <= gnd_q;
                anim_row     <= seq_row;
                anim_col     <= seq_col;
            end
        end
    end

    anim_sequencer #(
        .SRC_W       (SRC_W),
        .SRC_H       (SRC_H),
        .ANIM_COLS   (ANIM_COLS),
        .ANIM_FRAMES (ANIM_FRAMES),
        .ANIM_DIV    (ANIM_DIV)
    ) u_anim (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (anim_en),
        .walking (walking_q),
        .row_off (seq_row),
        .col_off (seq_col)
    );

endmodule
